// File: rtl/pio_dw_dealign_pkg.sv
// Shared widths, field offsets and FSM encoding for the PIO DW de-aligner.
package pio_dw_dealign_pkg;

    localparam int PIO_DATA_W     = 256;
    localparam int PIO_KEEP_W     = 8;
    localparam int BYTES_PER_BEAT = 4 * PIO_KEEP_W;
    localparam int ALIGN_HEAD_W   = 108;

    localparam int HEAD_TYPE_HI = 99;
    localparam int HEAD_TYPE_LO = 96;
    localparam int HEAD_ADDR_HI = 95;
    localparam int HEAD_ADDR_LO = 32;
    localparam int HEAD_BLEN_HI = 12;
    localparam int HEAD_BLEN_LO = 0;

    localparam int USER_TYPE_HI  = 107;
    localparam int USER_TYPE_LO  = 104;
    localparam int USER_ADDR_HI  = 95;
    localparam int USER_ADDR_LO  = 32;
    localparam int USER_DWLEN_HI = 18;
    localparam int USER_DWLEN_LO = 8;
    localparam int USER_FBE_HI   = 7;
    localparam int USER_FBE_LO   = 4;
    localparam int USER_LBE_HI   = 3;
    localparam int USER_LBE_LO   = 0;

    typedef enum logic [1:0] {
        S_SOP   = 2'd0,
        S_MID   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pio_be_decode.sv
// Byte-enable decode: first-byte offset, last-DW byte count, packet byte length
// and valid bytes in the final aligned beat.
module pio_be_decode
    import pio_dw_dealign_pkg::*;
(
    input  logic [3:0]  fbe,
    input  logic [3:0]  lbe,
    input  logic [10:0] dw_len,
    output logic [1:0]  off,
    output logic [2:0]  lb,
    output logic [12:0] byte_len,
    output logic [5:0]  vb
);

    logic [2:0] fb;
    logic [3:0] dw_last;

    always_comb begin
        if (fbe[0])      off = 2'd0;
        else if (fbe[1]) off = 2'd1;
        else if (fbe[2]) off = 2'd2;
        else             off = 2'd3;

        fb = {2'b0, fbe[0]} + {2'b0, fbe[1]} + {2'b0, fbe[2]} + {2'b0, fbe[3]};
        lb = {2'b0, lbe[0]} + {2'b0, lbe[1]} + {2'b0, lbe[2]} + {2'b0, lbe[3]};

        if (dw_len == 11'd1)
            byte_len = {10'b0, fb};
        else
            byte_len = {dw_len, 2'b00} - {11'b0, off} - (13'd4 - {10'b0, lb});

        // DWs in the last aligned beat: ((dw_len-1) mod 8) + 1
        dw_last = {1'b0, dw_len[2:0] - 3'd1} + 4'd1;
        vb      = {dw_last, 2'b00} - (6'd4 - {3'b0, lb});
    end

endmodule

// File: rtl/pio_dw_dealign.sv
// DW-aligned AXI-S request to byte-packed stream; one-beat store-forward
// with a flush beat when the last input beat spills past the shift.
module pio_dw_dealign
    import pio_dw_dealign_pkg::*;
#(
    parameter int USER_WIDTH = ALIGN_HEAD_W,
    parameter int HEAD_WIDTH = ALIGN_HEAD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  align_valid,
    input  logic                  align_last,
    input  logic [USER_WIDTH-1:0] align_user,
    input  logic [PIO_DATA_W-1:0] align_data,
    output logic                  align_ready,
    output logic                  unalign_valid,
    output logic                  unalign_last,
    output logic [HEAD_WIDTH-1:0] unalign_head,
    output logic [PIO_DATA_W-1:0] unalign_data,
    input  logic                  unalign_ready
);

    localparam logic [PIO_DATA_W-1:0] ONE = 1;
    localparam int XW = ((HEAD_WIDTH < USER_WIDTH) ? HEAD_WIDTH : USER_WIDTH) - ALIGN_HEAD_W;

    state_t state, state_nx;

    logic [PIO_DATA_W-1:0] hold_q, merged, flushed, raw, keep;
    logic [HEAD_WIDTH-1:0] head_q, head_nx, head_ext;
    logic [12:0] byte_cnt, blen_q;
    logic [5:0]  vb_q;
    logic [1:0]  off_q;
    logic [4:0]  sh;
    logic [4:0]  rem;

    logic [1:0]  dec_off;
    logic [2:0]  dec_lb;
    logic [12:0] dec_blen;
    logic [5:0]  dec_vb;

    logic in_hs, out_hs, fin;
    logic unused;

    pio_be_decode u_dec (
        .fbe      (align_user[USER_FBE_HI:USER_FBE_LO]),
        .lbe      (align_user[USER_LBE_HI:USER_LBE_LO]),
        .dw_len   (align_user[USER_DWLEN_HI:USER_DWLEN_LO]),
        .off      (dec_off),
        .lb       (dec_lb),
        .byte_len (dec_blen),
        .vb       (dec_vb)
    );

    assign unused = ^{dec_lb, align_user};

    if (XW > 0) begin : g_ext
        always_comb begin
            head_ext = '0;
            head_ext[ALIGN_HEAD_W +: XW] = align_user[ALIGN_HEAD_W +: XW];
        end
    end else begin : g_noext
        assign head_ext = '0;
    end

    always_comb begin
        head_nx = head_ext;
        head_nx[HEAD_TYPE_HI:HEAD_TYPE_LO] = align_user[USER_TYPE_HI:USER_TYPE_LO];
        head_nx[HEAD_ADDR_HI:HEAD_ADDR_LO] = {align_user[USER_ADDR_HI:USER_ADDR_LO+2], dec_off};
        head_nx[HEAD_BLEN_HI:HEAD_BLEN_LO] = dec_blen;
    end

    assign off_q  = head_q[HEAD_ADDR_LO+1:HEAD_ADDR_LO];
    assign blen_q = head_q[HEAD_BLEN_HI:HEAD_BLEN_LO];
    assign sh     = {off_q, 3'b000};
    assign rem    = blen_q[4:0];

    assign flushed = hold_q >> sh;
    assign merged  = (off_q == 2'd0) ? hold_q
                   : (flushed | (align_data << (9'd256 - {4'b0, sh})));

    always_comb begin
        state_nx      = state;
        align_ready   = 1'b0;
        unalign_valid = 1'b0;
        unalign_last  = 1'b0;
        raw           = '0;
        unique case (state)
            S_SOP: begin
                align_ready = 1'b1;
                if (align_valid)
                    state_nx = align_last ? S_FLUSH : S_MID;
            end
            S_MID: begin
                unalign_valid = align_valid;
                align_ready   = unalign_ready;
                raw           = merged;
                unalign_last  = align_last && ({4'b0, off_q} >= vb_q);
                if (align_valid && unalign_ready && align_last)
                    state_nx = unalign_last ? S_SOP : S_FLUSH;
            end
            S_FLUSH: begin
                unalign_valid = 1'b1;
                unalign_last  = 1'b1;
                raw           = flushed;
                if (unalign_ready)
                    state_nx = S_SOP;
            end
            default: state_nx = S_SOP;
        endcase
    end

    // zero the tail of a partial final beat
    assign keep = (unalign_last && rem != 5'd0)
                ? ((ONE << {rem, 3'b000}) - ONE) : '1;
    assign unalign_data = unalign_valid ? (raw & keep) : '0;
    assign unalign_head = head_q;

    assign in_hs  = align_valid & align_ready;
    assign out_hs = unalign_valid & unalign_ready;
    assign fin    = out_hs & unalign_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_SOP;
            hold_q   <= '0;
            head_q   <= '0;
            vb_q     <= '0;
            byte_cnt <= '0;
        end else begin
            state <= state_nx;
            if (fin)
                hold_q <= '0;
            else if (in_hs)
                hold_q <= align_data;
            if (fin)
                head_q <= '0;
            else if (in_hs && state == S_SOP)
                head_q <= head_nx;
            if (in_hs && state == S_SOP)
                vb_q <= dec_vb;
            if (fin)
                byte_cnt <= '0;
            else if (out_hs)
                byte_cnt <= byte_cnt + 13'(BYTES_PER_BEAT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && unalign_valid)
            assert (unalign_last == ((blen_q - byte_cnt) <= 13'(BYTES_PER_BEAT)));
    end

endmodule

// File: tb/tb_pio_dw_dealign.sv
// Directed table-driven bench for pio_dw_dealign with stall and
// mid-packet reset sequences.
module tb_pio_dw_dealign;
    import pio_dw_dealign_pkg::*;

    localparam int W  = PIO_DATA_W;
    localparam int UW = ALIGN_HEAD_W;
    localparam int HW = ALIGN_HEAD_W;

    typedef struct {
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [10:0] dw;
        logic [3:0]  typ;
        logic [63:0] addr;
        int          nin;
        int          blen;
        logic [1:0]  alo;
        int          nout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          align_valid = 1'b0;
    logic          align_last = 1'b0;
    logic [UW-1:0] align_user = '0;
    logic [W-1:0]  align_data = '0;
    logic          align_ready;
    logic          unalign_valid;
    logic          unalign_last;
    logic [HW-1:0] unalign_head;
    logic [W-1:0]  unalign_data;
    logic          unalign_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    vec_t tab[9];

    always #5 clk = ~clk;

    pio_dw_dealign #(.USER_WIDTH(UW), .HEAD_WIDTH(HW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .align_valid   (align_valid),
        .align_last    (align_last),
        .align_user    (align_user),
        .align_data    (align_data),
        .align_ready   (align_ready),
        .unalign_valid (unalign_valid),
        .unalign_last  (unalign_last),
        .unalign_head  (unalign_head),
        .unalign_data  (unalign_data),
        .unalign_ready (unalign_ready)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] sb(input int p, input int g);
        return 8'((p * 37 + g * 5 + 3) & 255);
    endfunction

    function automatic logic [W-1:0] in_beat(input int p, input int i);
        logic [W-1:0] b;
        for (int j = 0; j < 32; j++) b[8*j +: 8] = sb(p, i * 32 + j);
        return b;
    endfunction

    function automatic logic [W-1:0] exp_beat(input vec_t v, input int p, input int m);
        logic [W-1:0] b;
        for (int j = 0; j < 32; j++) begin
            int k;
            k = m * 32 + j;
            b[8*j +: 8] = (k < v.blen) ? sb(p, int'(v.alo) + k) : 8'h00;
        end
        return b;
    endfunction

    function automatic logic [UW-1:0] mk_user(input vec_t v);
        logic [UW-1:0] u;
        u = '0;
        u[107:104] = v.typ;
        u[95:32]   = v.addr;
        u[18:8]    = v.dw;
        u[7:4]     = v.fbe;
        u[3:0]     = v.lbe;
        return u;
    endfunction

    function automatic logic [HW-1:0] mk_head(input vec_t v);
        logic [HW-1:0] h;
        h = '0;
        h[99:96] = v.typ;
        h[95:32] = {v.addr[63:2], v.alo};
        h[12:0]  = 13'(v.blen);
        return h;
    endfunction

    task automatic run_pkt(input int t, input int p, input bit stall);
        vec_t v;
        int ii, oo, cyc;
        bit stalled;
        logic [W-1:0] pd;
        logic pl;
        logic [HW-1:0] ph;
        v = tab[t];
        ii = 0; oo = 0; cyc = 0; stalled = 0;
        pd = '0; pl = 0; ph = '0;
        while (oo < v.nout && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ii < v.nin) begin
                align_valid = 1'b1;
                align_data  = in_beat(p, ii);
                align_last  = (ii == v.nin - 1);
                align_user  = (ii == 0) ? mk_user(v) : '0;
            end else begin
                align_valid = 1'b0;
                align_last  = 1'b0;
                align_data  = '0;
                align_user  = '0;
            end
            unalign_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (stalled) begin
                chk($sformatf("t%0d stall_valid", t), W'(unalign_valid), W'(1));
                chk($sformatf("t%0d stall_data", t), unalign_data, pd);
                chk($sformatf("t%0d stall_last", t), W'(unalign_last), W'(pl));
                chk($sformatf("t%0d stall_head", t), W'(unalign_head), W'(ph));
            end
            stalled = 0;
            if (unalign_valid) begin
                if (unalign_ready) begin
                    chk($sformatf("t%0d b%0d data", t, oo), unalign_data, exp_beat(v, p, oo));
                    chk($sformatf("t%0d b%0d last", t, oo), W'(unalign_last), W'(oo == v.nout - 1));
                    chk($sformatf("t%0d b%0d head", t, oo), W'(unalign_head), W'(mk_head(v)));
                    oo++;
                end else begin
                    stalled = 1;
                    pd = unalign_data;
                    pl = unalign_last;
                    ph = unalign_head;
                end
            end
            if (align_valid && align_ready) ii++;
        end
        chk($sformatf("t%0d beats", t), W'(oo), W'(v.nout));
        chk($sformatf("t%0d consumed", t), W'(ii), W'(v.nin));
        if (stall) begin
            @(negedge clk);
            align_valid = 1'b0;
            align_last  = 1'b0;
            unalign_ready = 1'b1;
            #1;
            chk($sformatf("t%0d idle_valid", t), W'(unalign_valid), W'(0));
            chk($sformatf("t%0d idle_ready", t), W'(align_ready), W'(1));
            chk($sformatf("t%0d idle_head", t), W'(unalign_head), W'(0));
        end
    endtask

    initial begin
        tab[0] = '{4'hF, 4'hF, 11'd16, 4'h3, 64'h0000_1234_5678_9A00, 2, 64, 2'd0, 2};
        tab[1] = '{4'hE, 4'h1, 11'd9,  4'h5, 64'h0000_0000_0000_1000, 2, 32, 2'd1, 1};
        tab[2] = '{4'hC, 4'hF, 11'd8,  4'hA, 64'hFFFF_0000_0000_0040, 1, 30, 2'd2, 1};
        tab[3] = '{4'h8, 4'hF, 11'd17, 4'h1, 64'h0000_0001_0000_0080, 3, 65, 2'd3, 3};
        tab[4] = '{4'h6, 4'hF, 11'd1,  4'h7, 64'h0000_0000_0000_0204, 1, 2,  2'd1, 1};
        tab[5] = '{4'hF, 4'h3, 11'd10, 4'h2, 64'h0000_0000_0000_0300, 2, 38, 2'd0, 2};
        tab[6] = '{4'hE, 4'hF, 11'd8,  4'h9, 64'h0000_0000_0000_0400, 1, 31, 2'd1, 1};
        tab[7] = '{4'hC, 4'h7, 11'd24, 4'hC, 64'h0000_0000_0000_0500, 3, 93, 2'd2, 3};
        tab[8] = '{4'h8, 4'h1, 11'd9,  4'hF, 64'h0000_0000_0000_0600, 2, 30, 2'd3, 1};

        #1;
        chk("rst_valid", W'(unalign_valid), W'(0));
        chk("rst_last", W'(unalign_last), W'(0));
        chk("rst_head", W'(unalign_head), W'(0));
        chk("rst_data", unalign_data, W'(0));
        chk("rst_ready", W'(align_ready), W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 9; t++) run_pkt(t, t, 1'b0);
        for (int t = 0; t < 9; t++) run_pkt(t, t + 10, 1'b1);

        // reset while a 3-beat packet is stalled mid-stream
        @(negedge clk);
        align_valid = 1'b1;
        align_last  = 1'b0;
        align_user  = mk_user(tab[3]);
        align_data  = in_beat(30, 0);
        unalign_ready = 1'b1;
        #1;
        chk("mr_sop_ready", W'(align_ready), W'(1));
        @(negedge clk);
        align_user  = '0;
        align_data  = in_beat(30, 1);
        unalign_ready = 1'b0;
        #1;
        chk("mr_mid_valid", W'(unalign_valid), W'(1));
        chk("mr_mid_ready", W'(align_ready), W'(0));
        @(negedge clk);
        #1;
        chk("mr_hold_data", unalign_data, exp_beat(tab[3], 30, 0));
        align_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", W'(unalign_valid), W'(0));
        chk("mr_last", W'(unalign_last), W'(0));
        chk("mr_head", W'(unalign_head), W'(0));
        chk("mr_data", unalign_data, W'(0));
        chk("mr_ready", W'(align_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        unalign_ready = 1'b1;
        run_pkt(0, 40, 1'b0);
        run_pkt(3, 41, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
